led_pwm_driver: RTL and testbench

LED_PWM_DRIVER -- requirements
Module: led_pwm_driver

---
 rtl/led_pwm_driver.sv | 152 +++++++++++++++
 tb/tb_led_pwm_driver.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pwm_driver.sv
// ---------------------------------------------------------------------------
// led_pwm_driver
// Frame-based PWM dimmer and blinker for a bank of active-high LEDs.
// A prescaler divides the clock into PWM steps; 16 steps form one frame.
// The LED pattern and the duty value are captured at each frame boundary,
// so changes made mid-frame never glitch the frame being displayed.
//
// Parameters
//   PRESCALE        clock cycles per PWM step (1..65535)
//   N_LEDS          number of physical LED outputs (fixed at 10)
// Ports
//   i_CLK           system clock, rising edge
//   i_RESET_n       synchronous active-low reset
//   i_Data          LED pattern, bits [N_LEDS-1:0] used
//   i_Ctrl_Data     control write data: [3:0] DUTY, [4] BLINK_EN, [7:5] RATE
//   i_Ctrl_Write_EN control write strobe, active high
//   o_Ctrl_Data     control register readback, [15:8] read as zero
//   o_LED           registered LED drive, active high
//   o_Frame_Tick    one-cycle pulse after each frame boundary
// ---------------------------------------------------------------------------
module led_pwm_driver #(
    parameter int unsigned PRESCALE = 50,
    parameter int unsigned N_LEDS   = 10
) (
    input  logic              i_CLK,
    input  logic              i_RESET_n,
    input  logic [15:0]       i_Data,
    input  logic [15:0]       i_Ctrl_Data,
    input  logic              i_Ctrl_Write_EN,
    output logic [15:0]       o_Ctrl_Data,
    output logic [N_LEDS-1:0] o_LED,
    output logic              o_Frame_Tick
);

    localparam int unsigned PRESC_W = 16;
    localparam int unsigned STEP_W  = 4;
    localparam int unsigned DUTY_W  = 4;
    localparam int unsigned CTRL_W  = 8;
    localparam int unsigned FCNT_W  = 10;
    localparam int unsigned THR_W   = FCNT_W + 1;

    localparam logic [CTRL_W-1:0]  CTRL_RST   = 8'h0F;
    localparam logic [DUTY_W-1:0]  DUTY_RST   = 4'hF;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);
    localparam logic [STEP_W-1:0]  STEP_LAST  = 4'hF;

    // State registers
    logic [CTRL_W-1:0]  ctrl_q,   ctrl_d;
    logic [PRESC_W-1:0] presc_q,  presc_d;
    logic [STEP_W-1:0]  step_q,   step_d;
    logic [N_LEDS-1:0]  shadow_q, shadow_d;
    logic [DUTY_W-1:0]  aduty_q,  aduty_d;
    logic [FCNT_W-1:0]  fcnt_q,   fcnt_d;
    logic               blink_q,  blink_d;
    logic [N_LEDS-1:0]  led_q,    led_d;
    logic               tick_q,   tick_d;

    // Decoded control fields and timing strobes
    logic [DUTY_W-1:0]  ctrl_duty;
    logic               ctrl_blink_en;
    logic [2:0]         ctrl_rate;
    logic               step_adv;
    logic               frame_bnd;
    logic [THR_W-1:0]   blink_thr;

    // Upper data bits carry nothing for this block
    logic unused_bits;
    assign unused_bits = ^{i_Data[15:N_LEDS], i_Ctrl_Data[15:CTRL_W]};

    assign ctrl_duty     = ctrl_q[3:0];
    assign ctrl_blink_en = ctrl_q[4];
    assign ctrl_rate     = ctrl_q[7:5];

    assign step_adv  = (presc_q == PRESC_LAST);
    assign frame_bnd = step_adv && (step_q == STEP_LAST);

    // Blink toggles once the frame counter reaches 2^(RATE+3)-1; an extra bit
    // keeps RATE=7 (threshold 1023) exact before narrowing the compare.
    assign blink_thr = (THR_W'(1) << (THR_W'(ctrl_rate) + THR_W'(3))) - THR_W'(1);

    // Next-state and output logic
    always_comb begin
        ctrl_d   = ctrl_q;
        presc_d  = presc_q + PRESC_W'(1);
        step_d   = step_q;
        shadow_d = shadow_q;
        aduty_d  = aduty_q;
        fcnt_d   = fcnt_q;
        blink_d  = blink_q;
        tick_d   = frame_bnd;
        // LED-on uses the current step/phase, so the pins lag by one cycle
        led_d    = ((step_q <= aduty_q) && !blink_q) ? shadow_q : '0;

        if (step_adv) begin
            presc_d = '0;
            step_d  = step_q + STEP_W'(1);
        end

        // Frame boundary: capture pattern and duty, advance the blink timer
        if (frame_bnd) begin
            shadow_d = i_Data[N_LEDS-1:0];
            aduty_d  = ctrl_duty;
            if (ctrl_blink_en) begin
                if ({1'b0, fcnt_q} == blink_thr) begin
                    blink_d = !blink_q;
                    fcnt_d  = '0;
                end else begin
                    fcnt_d  = fcnt_q + FCNT_W'(1);
                end
            end
        end

        // Control write; disabling blink wins over a coincident frame update
        if (i_Ctrl_Write_EN) begin
            ctrl_d = i_Ctrl_Data[CTRL_W-1:0];
            if (!i_Ctrl_Data[4]) begin
                fcnt_d  = '0;
                blink_d = 1'b0;
            end
        end
    end

    // State register with synchronous reset
    always_ff @(posedge i_CLK) begin
        if (!i_RESET_n) begin
            ctrl_q   <= CTRL_RST;
            presc_q  <= '0;
            step_q   <= '0;
            shadow_q <= '0;
            aduty_q  <= DUTY_RST;
            fcnt_q   <= '0;
            blink_q  <= 1'b0;
            led_q    <= '0;
            tick_q   <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            presc_q  <= presc_d;
            step_q   <= step_d;
            shadow_q <= shadow_d;
            aduty_q  <= aduty_d;
            fcnt_q   <= fcnt_d;
            blink_q  <= blink_d;
            led_q    <= led_d;
            tick_q   <= tick_d;
        end
    end

    assign o_Ctrl_Data  = {(16 - CTRL_W)'(0), ctrl_q};
    assign o_LED        = led_q;
    assign o_Frame_Tick = tick_q;

endmodule

// File: tb/tb_led_pwm_driver.sv
// ---------------------------------------------------------------------------
// tb_led_pwm_driver
// Self-checking bench for led_pwm_driver with PRESCALE=2 (32-cycle frames).
// Directed tables and sequences plus randomized traffic; a reference model
// derived from elapsed cycles since reset checks every cycle.
// ---------------------------------------------------------------------------
module tb_led_pwm_driver;

    localparam int unsigned P     = 2;
    localparam int unsigned FRAME = 16 * P;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data  = 16'h0000;
    logic [15:0] wdata = 16'h0000;
    logic        we    = 1'b0;
    logic [15:0] ctrl_rd;
    logic [9:0]  led;
    logic        tick;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    led_pwm_driver #(.PRESCALE(P), .N_LEDS(10)) dut (
        .i_CLK          (clk),
        .i_RESET_n      (rst_n),
        .i_Data         (data),
        .i_Ctrl_Data    (wdata),
        .i_Ctrl_Write_EN(we),
        .o_Ctrl_Data    (ctrl_rd),
        .o_LED          (led),
        .o_Frame_Tick   (tick)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    // Reference model: position in the frame follows from cycles since reset
    logic [7:0] m_ctrl   = 8'h0F;
    logic [9:0] m_shadow = 10'h0;
    logic [9:0] m_led    = 10'h0;
    int         m_aduty  = 15;
    int         m_cnt    = 0;
    int         m_cyc    = 0;
    int         m_step   = 0;
    int         m_thr    = 0;
    bit         m_blink  = 1'b0;
    bit         m_tick   = 1'b0;
    bit         m_bnd    = 1'b0;
    bit         m_valid  = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_ctrl = 8'h0F; m_shadow = 10'h0; m_aduty = 15; m_cnt = 0;
            m_blink = 1'b0; m_cyc = 0; m_led = 10'h0; m_tick = 1'b0;
            m_valid = 1'b1;
        end else begin
            m_step = (m_cyc / P) % 16;
            m_bnd  = (m_cyc % FRAME) == (FRAME - 1);
            m_led  = (m_step <= m_aduty && !m_blink) ? m_shadow : 10'h0;
            m_tick = m_bnd;
            if (m_bnd) begin
                m_shadow = data[9:0];
                m_aduty  = int'(m_ctrl[3:0]);
                if (m_ctrl[4]) begin
                    m_thr = (1 << (int'(m_ctrl[7:5]) + 3)) - 1;
                    if (m_cnt == m_thr) begin
                        m_blink = !m_blink;
                        m_cnt   = 0;
                    end else begin
                        m_cnt = (m_cnt + 1) % 1024;
                    end
                end
            end
            if (we) begin
                m_ctrl = wdata[7:0];
                if (!wdata[4]) begin
                    m_cnt   = 0;
                    m_blink = 1'b0;
                end
            end
            m_cyc++;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_led",  32'(led),     32'(m_led));
            check("model_tick", 32'(tick),    32'(m_tick));
            check("model_ctrl", 32'(ctrl_rd), {24'h0, m_ctrl});
        end
    end

    // Drive a one-cycle control write; returns on the sample after it lands
    task automatic write_ctrl(input logic [15:0] v);
        we    = 1'b1;
        wdata = v;
        @(negedge clk);
        we    = 1'b0;
    endtask

    // Returns on the sample where o_Frame_Tick is high, bounded
    task automatic wait_tick();
        bit found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            found = tick;
        end
        check("wait_tick", 32'(found), 32'd1);
    endtask

    // After reset release with pattern 3FF: 32 dark cycles, one tick, then on
    task automatic check_reset_frame(input string name);
        int bad   = 0;
        int ticks = 0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (led !== 10'h000) bad++;
            if (tick) begin
                ticks++;
                if (k != 31) bad++;
            end
        end
        check({name, "_dark"}, 32'(bad), 32'd0);
        check({name, "_tick"}, 32'(ticks), 32'd1);
        bad = 0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (led !== 10'h3FF) bad++;
        end
        check({name, "_on"}, 32'(bad), 32'd0);
        check({name, "_ctrl"}, 32'(ctrl_rd), 32'h000F);
    endtask

    typedef struct {
        logic [15:0] wr;
        logic [15:0] rd;
    } rb_vec_t;

    typedef struct {
        logic [15:0] ctrl;
        logic [9:0]  pat;
        int          on_cyc;
    } duty_vec_t;

    rb_vec_t   rbv[5];
    duty_vec_t dv[5];

    initial begin
        int bad;
        bit found;

        rbv[0] = '{16'hFFFF, 16'h00FF};
        rbv[1] = '{16'h0003, 16'h0003};
        rbv[2] = '{16'hA5E7, 16'h00E7};
        rbv[3] = '{16'h1234, 16'h0034};
        rbv[4] = '{16'h000F, 16'h000F};

        dv[0] = '{16'h0003, 10'h155, 8};
        dv[1] = '{16'h0000, 10'h2AA, 2};
        dv[2] = '{16'h0007, 10'h3C3, 16};
        dv[3] = '{16'h000F, 10'h155, 32};
        dv[4] = '{16'h000A, 10'h0FF, 22};

        // Reset and first frame
        rst_n = 1'b0;
        data  = 16'h03FF;
        repeat (3) @(negedge clk);
        check("reset_led",  32'(led),     32'h0);
        check("reset_tick", 32'(tick),    32'h0);
        check("reset_ctrl", 32'(ctrl_rd), 32'h000F);
        rst_n = 1'b1;
        check_reset_frame("reset");

        // Control readback
        for (int i = 0; i < 5; i++) begin
            write_ctrl(rbv[i].wr);
            check("readback", 32'(ctrl_rd), 32'(rbv[i].rd));
        end

        // Duty cycle per frame
        for (int i = 0; i < 5; i++) begin
            data = {6'h3F, dv[i].pat};
            write_ctrl(dv[i].ctrl);
            wait_tick();
            wait_tick();
            bad = 0;
            for (int k = 0; k < 32; k++) begin
                @(negedge clk);
                if (led !== ((k < dv[i].on_cyc) ? dv[i].pat : 10'h000)) bad++;
            end
            check("duty_frame", 32'(bad), 32'd0);
        end

        // Mid-frame pattern change only shows in the next frame
        data = 16'h0001;
        write_ctrl(16'h000F);
        wait_tick();
        wait_tick();
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (led !== 10'h001) bad++;
        end
        data  = 16'h0200;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (led !== 10'h001) bad++;
            found = tick;
        end
        check("glitch_old",  32'(bad),   32'd0);
        check("glitch_tick", 32'(found), 32'd1);
        bad = 0;
        repeat (32) begin
            @(negedge clk);
            if (led !== 10'h200) bad++;
        end
        check("glitch_new", 32'(bad), 32'd0);

        // Blink RATE=0: 8 frames on, 8 frames off
        data = 16'h03FF;
        wait_tick();
        write_ctrl(16'h001F);
        for (int f = 1; f <= 25; f++) begin
            wait_tick();
            @(negedge clk);
            check("blink_frame", 32'(led), ((f / 8) % 2 == 0) ? 32'h3FF : 32'h0);
        end
        repeat (5) @(negedge clk);
        write_ctrl(16'h000F);
        @(negedge clk);
        check("blink_off_write", 32'(led), 32'h3FF);

        // Reset at step 7 during the blink off phase
        wait_tick();
        write_ctrl(16'h001F);
        repeat (8) wait_tick();
        repeat (14) @(negedge clk);
        check("pre_reset_off", 32'(led), 32'h0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_led",  32'(led),     32'h0);
        check("midreset_tick", 32'(tick),    32'h0);
        check("midreset_ctrl", 32'(ctrl_rd), 32'h000F);
        rst_n = 1'b1;
        check_reset_frame("midreset");

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            we = ($urandom_range(0, 15) == 0);
            if (we) begin
                wdata = 16'($urandom);
                if ($urandom_range(0, 1) == 1) wdata[7:5] = 3'b000;
            end
            if ($urandom_range(0, 31) == 0) data = 16'($urandom);
            rst_n = ($urandom_range(0, 799) != 0);
            @(negedge clk);
        end
        we    = 1'b0;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete, failures=%0d", failures);
        $fatal(1, "timeout");
    end

endmodule
